// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: BCD time-of-day counter with prescaler, validated time load and 12/24-hour display.
// Ports: clk/rst (sync, active-high); en gates counting; load_valid/load_ready/load_time set the time,
// load_err flags rejected loads; time_bcd is 24-hour BCD; disp_hour/pm format the hour;
// sec_tick/min_tick/day_tick pulse one cycle after each rollover.
module rtc_timekeeper #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mode12,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [23:0] load_time,
  output logic        load_err,
  output logic [23:0] time_bcd,
  output logic [7:0]  disp_hour,
  output logic        pm,
  output logic        sec_tick,
  output logic        min_tick,
  output logic        day_tick
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] presc;
  logic [23:0] t, nxt;
  logic wrap, xfer, ld_ok, s_end, m_end, h_end;
  logic [4:0] hb, h12;
  assign time_bcd   = t;
  assign load_ready = ~rst;
  assign xfer       = load_valid & load_ready;
  assign wrap       = en && presc == PW'(TICK_DIV - 1);
  assign s_end      = t[3:0] == 4'd9 && t[7:4] == 4'd5;
  assign m_end      = t[11:8] == 4'd9 && t[15:12] == 4'd5;
  assign h_end      = t[23:16] == 8'h23;
  assign ld_ok = load_time[3:0] <= 4'd9 && load_time[7:4] <= 4'd5 &&
                 load_time[11:8] <= 4'd9 && load_time[15:12] <= 4'd5 &&
                 load_time[19:16] <= 4'd9 &&
                 (load_time[23:20] < 4'd2 || (load_time[23:20] == 4'd2 && load_time[19:16] <= 4'd3));
  always_comb begin
    nxt[3:0]   = t[3:0] == 4'd9 ? 4'd0 : t[3:0] + 4'd1;
    nxt[7:4]   = t[3:0] != 4'd9 ? t[7:4] : t[7:4] == 4'd5 ? 4'd0 : t[7:4] + 4'd1;
    nxt[11:8]  = !s_end ? t[11:8] : t[11:8] == 4'd9 ? 4'd0 : t[11:8] + 4'd1;
    nxt[15:12] = !(s_end && t[11:8] == 4'd9) ? t[15:12] : t[15:12] == 4'd5 ? 4'd0 : t[15:12] + 4'd1;
    nxt[23:16] = !(s_end && m_end) ? t[23:16] : h_end ? 8'h00 :
                 t[19:16] == 4'd9 ? {t[23:20] + 4'd1, 4'd0} : {t[23:20], t[19:16] + 4'd1};
  end
  assign hb        = {1'b0, t[23:20]} * 5'd10 + {1'b0, t[19:16]};
  assign h12       = hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
  assign pm        = hb >= 5'd12;
  assign disp_hour = !mode12 ? t[23:16] : h12 >= 5'd10 ? {4'd1, h12[3:0] - 4'd10} : {4'd0, h12[3:0]};
  // A load transfer (accepted or rejected) pre-empts the prescaler and the time advance that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      t        <= '0;
      presc    <= '0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
      day_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= wrap & ~xfer;
      min_tick <= wrap & ~xfer & s_end & m_end | wrap & ~xfer & s_end;
      day_tick <= wrap & ~xfer & s_end & m_end & h_end;
      load_err <= xfer & ~ld_ok;
      if (xfer) begin
        if (ld_ok) begin
          t     <= load_time;
          presc <= '0;
        end
      end else if (en) begin
        presc <= wrap ? '0 : presc + PW'(1);
        if (wrap) t <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed scoreboard bench for rtc_timekeeper with TICK_DIV=4.
module tb_rtc_timekeeper;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, mode12 = 1'b0, load_valid = 1'b0;
  logic load_ready, load_err, pm, sec_tick, min_tick, day_tick;
  logic [23:0] load_time = '0, time_bcd;
  logic [7:0] disp_hour;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [23:0] t; logic s, m, d, e;} exp_t;
  exp_t q[$];

  rtc_timekeeper #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode12(mode12),
    .load_valid(load_valid), .load_ready(load_ready), .load_time(load_time),
    .load_err(load_err), .time_bcd(time_bcd), .disp_hour(disp_hour), .pm(pm),
    .sec_tick(sec_tick), .min_tick(min_tick), .day_tick(day_tick)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] ex);
    n_cmp++;
    assert (obs === ex) else begin
      n_bad++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, ex);
    end
  endtask

  task automatic push(input logic [23:0] t, input logic s, input logic m, input logic d, input logic e);
    q.push_back('{t: t, s: s, m: m, d: d, e: e});
  endtask

  task automatic step_chk(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      x = q.pop_front();
      cmp({tag, ".time"}, time_bcd, x.t);
      cmp({tag, ".sec"}, {23'd0, sec_tick}, {23'd0, x.s});
      cmp({tag, ".min"}, {23'd0, min_tick}, {23'd0, x.m});
      cmp({tag, ".day"}, {23'd0, day_tick}, {23'd0, x.d});
      cmp({tag, ".err"}, {23'd0, load_err}, {23'd0, x.e});
    end
  endtask

  task automatic idle(input string tag, input int n, input logic [23:0] t);
    for (int i = 0; i < n; i++) begin
      push(t, 1'b0, 1'b0, 1'b0, 1'b0);
      step_chk(tag);
    end
  endtask

  task automatic tick(input string tag, input logic [23:0] t);
    push(t, 1'b1, 1'b0, 1'b0, 1'b0);
    step_chk(tag);
  endtask

  task automatic load(input string tag, input logic [23:0] v, input logic [23:0] t, input logic e);
    load_valid = 1'b1;
    load_time  = v;
    push(t, 1'b0, 1'b0, 1'b0, e);
    step_chk(tag);
    load_valid = 1'b0;
  endtask

  task automatic hour_chk(input string tag, input logic [23:0] v, input logic [7:0] dh, input logic p);
    load(tag, v, v, 1'b0);
    cmp({tag, ".disp"}, {16'd0, disp_hour}, {16'd0, dh});
    cmp({tag, ".pm"}, {23'd0, pm}, {23'd0, p});
  endtask

  initial begin
    idle("reset", 2, 24'h000000);
    cmp("reset.ready", {23'd0, load_ready}, 24'd0);
    rst = 1'b0;
    idle("run", 3, 24'h000000);
    tick("first_tick", 24'h000001);
    idle("run", 3, 24'h000001);
    tick("second_tick", 24'h000002);
    cmp("run.ready", {23'd0, load_ready}, 24'd1);

    load("load_235958", 24'h235958, 24'h235958, 1'b0);
    idle("pre_59", 3, 24'h235958);
    tick("to_235959", 24'h235959);
    idle("pre_day", 3, 24'h235959);
    push(24'h000000, 1'b1, 1'b1, 1'b1, 1'b0);
    step_chk("day_roll");

    load("bad_246000", 24'h246000, 24'h000000, 1'b1);
    idle("after_bad", 3, 24'h000000);
    tick("tick_after_bad", 24'h000001);
    idle("pre_wrap", 3, 24'h000001);
    load("bad_on_wrap", 24'h125A00, 24'h000001, 1'b1);
    tick("deferred_tick", 24'h000002);

    idle("pre_wrap2", 3, 24'h000002);
    load("good_on_wrap", 24'h123456, 24'h123456, 1'b0);
    idle("after_good", 3, 24'h123456);
    tick("tick_after_good", 24'h123457);
    en = 1'b0;
    idle("frozen", 10, 24'h123457);
    en = 1'b1;
    idle("resume", 3, 24'h123457);
    tick("resume_tick", 24'h123458);

    en = 1'b0;
    mode12 = 1'b1;
    hour_chk("h00", 24'h000000, 8'h12, 1'b0);
    hour_chk("h11", 24'h110000, 8'h11, 1'b0);
    hour_chk("h12", 24'h120000, 8'h12, 1'b1);
    hour_chk("h13", 24'h130000, 8'h01, 1'b1);
    hour_chk("h23", 24'h230000, 8'h11, 1'b1);
    idle("held_en0", 3, 24'h230000);
    mode12 = 1'b0;
    #1;
    cmp("h23_24h.disp", {16'd0, disp_hour}, 24'h000023);

    en = 1'b1;
    load("mid_count", 24'h123456, 24'h123456, 1'b0);
    idle("mid", 2, 24'h123456);
    rst = 1'b1;
    idle("rst_mid", 2, 24'h000000);
    cmp("rst_mid.ready", {23'd0, load_ready}, 24'd0);
    rst = 1'b0;
    idle("restart", 3, 24'h000000);
    tick("restart_tick", 24'h000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
